vram_arbiter: RTL and testbench

VRAM_ARBITER -- requirements
Module: vram_arbiter

---
 rtl/vram_arbiter.sv | 138 +++++++++++++
 tb/tb_vram_arbiter.sv | 291 +++++++++++++++++++++++++++++
 2 files changed

// File: rtl/vram_arbiter.sv
// vram_arbiter
//   Shares a single-port VRAM between the video fetcher and the CPU.
//   Video slots (vRd=1 on a ce) always win: the memory address is driven
//   from vA and writes are blocked. A CPU request is captured in IDLE,
//   waits out any video slots, gets one clean ce period of ACCESS, and is
//   then acknowledged with a single-clock cpuAck pulse in DONE.
//
// Build option:
//   CONTENTION_EN  when defined, cpuCe is held low while a CPU request is
//                  pending in IDLE/WAIT during the contention window (cn=1),
//                  mimicking ULA clock stretching. Those suppressed ce
//                  cycles also count toward stall. When undefined, cpuCe
//                  is simply ce and cn is ignored.
//
// Ports:
//   clock, reset      system clock, asynchronous active-high reset
//   ce                pixel clock enable (shared with the video fetcher)
//   vRd, vA, vD       video fetch slot, fetch address, fetched data
//   cn                contention window from video timing
//   cpuReq, cpuWr     CPU request (held until cpuAck) and write flag
//   cpuA, cpuDi       CPU address within the VRAM page, CPU write data
//   cpuDo, cpuAck     registered read data, one-clock completion pulse
//   cpuCe             CPU clock enable
//   memA, memDi       VRAM address, VRAM read data
//   memDo, memWe      VRAM write data, VRAM write strobe
//   stall             saturating count of ce cycles a CPU request waited

module vram_arbiter (
  input  logic        clock,
  input  logic        reset,
  input  logic        ce,
  input  logic        vRd,
  input  logic [12:0] vA,
  input  logic        cn,
  output logic [7:0]  vD,
  input  logic        cpuReq,
  input  logic        cpuWr,
  input  logic [13:0] cpuA,
  input  logic [7:0]  cpuDi,
  output logic [7:0]  cpuDo,
  output logic        cpuAck,
  output logic        cpuCe,
  output logic [13:0] memA,
  input  logic [7:0]  memDi,
  output logic [7:0]  memDo,
  output logic        memWe,
  output logic [7:0]  stall
);

  typedef enum logic [1:0] {
    S_IDLE   = 2'd0,
    S_WAIT   = 2'd1,
    S_ACCESS = 2'd2,
    S_DONE   = 2'd3
  } state_t;

  state_t      state;
  logic        cap_wr;
  logic [13:0] cap_a;
  logic [7:0]  cap_di;

  logic        ce_block;
  logic        waited;
  logic        stall_inc;

`ifdef CONTENTION_EN
  assign ce_block = cpuReq & cn & ((state == S_IDLE) | (state == S_WAIT));
`else
  logic unused_cn;
  assign unused_cn = cn;
  assign ce_block  = 1'b0;
`endif

  assign cpuCe = ce & ~ce_block;

  // Video owns the bus during its slot; otherwise the captured CPU address
  // stays on memA, so it naturally holds its last value while idle.
  assign memA  = vRd ? {1'b0, vA} : cap_a;
  assign memWe = (state == S_ACCESS) & cap_wr & ~vRd;
  assign memDo = cap_di;

  // A request "waits" on a ce when a video slot blocks it: at capture time,
  // while in WAIT, or when a video slot lands on top of ACCESS. A ce that is
  // both blocked and contended is counted once.
  assign waited = vRd & (((state == S_IDLE) & cpuReq) |
                         (state == S_WAIT) | (state == S_ACCESS));
  assign stall_inc = ce & (waited | ce_block);

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state  <= S_IDLE;
      cap_wr <= 1'b0;
      cap_a  <= 14'd0;
      cap_di <= 8'd0;
      cpuDo  <= 8'd0;
      cpuAck <= 1'b0;
      vD     <= 8'd0;
      stall  <= 8'd0;
    end else begin
      cpuAck <= 1'b0;

      if (ce && vRd)
        vD <= memDi;

      if (stall_inc && (stall != 8'hFF))
        stall <= stall + 8'd1;

      case (state)
        S_IDLE: begin
          if (ce && cpuReq) begin
            cap_wr <= cpuWr;
            cap_a  <= cpuA;
            cap_di <= cpuDi;
            state  <= vRd ? S_WAIT : S_ACCESS;
          end
        end
        S_WAIT: begin
          if (ce && !vRd)
            state <= S_ACCESS;
        end
        S_ACCESS: begin
          // A video slot colliding with ACCESS simply stretches it.
          if (ce && !vRd) begin
            if (!cap_wr)
              cpuDo <= memDi;
            cpuAck <= 1'b1;
            state  <= S_DONE;
          end
        end
        S_DONE: begin
          state <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_vram_arbiter.sv
module tb_vram_arbiter;

  logic        clock;
  logic        reset;
  logic        ce;
  logic        vRd;
  logic [12:0] vA;
  logic        cn;
  logic [7:0]  vD;
  logic        cpuReq;
  logic        cpuWr;
  logic [13:0] cpuA;
  logic [7:0]  cpuDi;
  logic [7:0]  cpuDo;
  logic        cpuAck;
  logic        cpuCe;
  logic [13:0] memA;
  logic [7:0]  memDi;
  logic [7:0]  memDo;
  logic        memWe;
  logic [7:0]  stall;

  vram_arbiter dut (
    .clock  (clock),
    .reset  (reset),
    .ce     (ce),
    .vRd    (vRd),
    .vA     (vA),
    .cn     (cn),
    .vD     (vD),
    .cpuReq (cpuReq),
    .cpuWr  (cpuWr),
    .cpuA   (cpuA),
    .cpuDi  (cpuDi),
    .cpuDo  (cpuDo),
    .cpuAck (cpuAck),
    .cpuCe  (cpuCe),
    .memA   (memA),
    .memDi  (memDi),
    .memDo  (memDo),
    .memWe  (memWe),
    .stall  (stall)
  );

`ifdef CONTENTION_EN
  localparam logic CONT_CE_EXP = 1'b0;
`else
  localparam logic CONT_CE_EXP = 1'b1;
`endif

  typedef struct {
    logic [7:0] do_exp;
    logic [7:0] stall_exp;
  } sb_item_t;

  sb_item_t sb_q[$];
  int n_tests = 0;
  int n_fail  = 0;
  int ack_count = 0;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  // Completion monitor: every cpuAck pops one expected transfer result.
  always @(negedge clock) begin
    if (cpuAck === 1'b1) begin
      ack_count++;
      if (sb_q.size() == 0) begin
        check("ack_unexpected", 32'd1, 32'd0);
      end else begin
        sb_item_t it;
        it = sb_q.pop_front();
        check("sb_cpuDo", {24'd0, cpuDo}, {24'd0, it.do_exp});
        check("sb_stall", {24'd0, stall}, {24'd0, it.stall_exp});
      end
    end
  end

  task automatic tick();
    @(posedge clock);
    #1;
  endtask

  task automatic ce_cycle();
    ce = 1'b1;
    tick();
    ce = 1'b0;
    tick();
  endtask

  task automatic request(input logic wr, input logic [13:0] a, input logic [7:0] di,
                         input logic expect_ack, input logic [7:0] do_exp,
                         input logic [7:0] stall_exp);
    sb_item_t it;
    cpuReq = 1'b1;
    cpuWr  = wr;
    cpuA   = a;
    cpuDi  = di;
    if (expect_ack) begin
      it.do_exp    = do_exp;
      it.stall_exp = stall_exp;
      sb_q.push_back(it);
    end
  endtask

  task automatic wait_ack(input string tag, input int budget);
    int start;
    int i;
    start = ack_count;
    i = 0;
    while (ack_count == start && i < budget) begin
      ce_cycle();
      i++;
    end
    check(tag, (ack_count != start) ? 32'd1 : 32'd0, 32'd1);
    cpuReq = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog expired");
  end

  initial begin
    int a0;
    reset  = 1'b1;
    ce     = 1'b0;
    vRd    = 1'b0;
    vA     = 13'd0;
    cn     = 1'b0;
    cpuReq = 1'b0;
    cpuWr  = 1'b0;
    cpuA   = 14'd0;
    cpuDi  = 8'd0;
    memDi  = 8'd0;

    // Reset values
    tick();
    tick();
    check("rst_cpuAck", {31'd0, cpuAck}, 32'd0);
    check("rst_memWe",  {31'd0, memWe},  32'd0);
    check("rst_cpuDo",  {24'd0, cpuDo},  32'd0);
    check("rst_vD",     {24'd0, vD},     32'd0);
    check("rst_memA",   {18'd0, memA},   32'd0);
    check("rst_memDo",  {24'd0, memDo},  32'd0);
    check("rst_stall",  {24'd0, stall},  32'd0);
    check("rst_cpuCe_lo", {31'd0, cpuCe}, 32'd0);
    ce = 1'b1;
    #1;
    check("rst_cpuCe_hi", {31'd0, cpuCe}, 32'd1);
    ce = 1'b0;
    tick();
    reset = 1'b0;
    tick();

    // Plain read, no video contention
    a0 = ack_count;
    memDi = 8'hA5;
    request(1'b0, 14'h1800, 8'h00, 1'b1, 8'hA5, 8'd0);
    ce_cycle();
    check("t1_memA",  {18'd0, memA}, 32'h1800);
    check("t1_memWe", {31'd0, memWe}, 32'd0);
    wait_ack("t1_ack_seen", 4);
    ce_cycle();
    ce_cycle();
    check("t1_ack_once", ack_count - a0, 32'd1);

    // Write held off by three video slots
    vRd = 1'b1;
    vA  = 13'h0555;
    request(1'b1, 14'h0010, 8'h3C, 1'b1, 8'hA5, 8'd3);
    for (int i = 0; i < 3; i++) begin
      ce_cycle();
      check("t2_we_blocked", {31'd0, memWe}, 32'd0);
      check("t2_memA_video", {18'd0, memA}, 32'h0555);
    end
    vRd = 1'b0;
    ce_cycle();
    check("t2_memWe", {31'd0, memWe}, 32'd1);
    check("t2_memA",  {18'd0, memA},  32'h0010);
    check("t2_memDo", {24'd0, memDo}, 32'h3C);
    wait_ack("t2_ack_seen", 4);

    // Video slot lands on a pending write in ACCESS
    request(1'b1, 14'h2222, 8'h77, 1'b1, 8'hA5, 8'd4);
    ce_cycle();
    check("t3_we_access", {31'd0, memWe}, 32'd1);
    vRd   = 1'b1;
    vA    = 13'h1ABC;
    memDi = 8'h5A;
    #1;
    check("t3_memA_video", {18'd0, memA}, 32'h1ABC);
    check("t3_we_video",   {31'd0, memWe}, 32'd0);
    ce_cycle();
    check("t3_vD",        {24'd0, vD},    32'h5A);
    check("t3_we_hold",   {31'd0, memWe}, 32'd0);
    vRd = 1'b0;
    #1;
    check("t3_we_resume", {31'd0, memWe}, 32'd1);
    check("t3_memA_cpu",  {18'd0, memA},  32'h2222);
    wait_ack("t3_ack_seen", 4);

    // Read captured during a video slot
    vRd   = 1'b1;
    vA    = 13'h0042;
    memDi = 8'h3E;
    request(1'b0, 14'h0FFF, 8'h00, 1'b1, 8'h3E, 8'd5);
    ce_cycle();
    check("t4_vD", {24'd0, vD}, 32'h3E);
    vRd = 1'b0;
    wait_ack("t4_ack_seen", 4);

    // Contention window for six ce periods
    cn    = 1'b1;
    vRd   = 1'b1;
    memDi = 8'h81;
    request(1'b0, 14'h3000, 8'h00, 1'b1, 8'h81, 8'd11);
    for (int i = 0; i < 6; i++) begin
      ce = 1'b1;
      #1;
      check("t5_cpuCe_cn", {31'd0, cpuCe}, {31'd0, CONT_CE_EXP});
      tick();
      ce = 1'b0;
      tick();
    end
    cn  = 1'b0;
    vRd = 1'b0;
    ce  = 1'b1;
    #1;
    check("t5_cpuCe_free", {31'd0, cpuCe}, 32'd1);
    tick();
    ce = 1'b0;
    tick();
    wait_ack("t5_ack_seen", 4);

    // Stall saturation
    vRd   = 1'b1;
    memDi = 8'h42;
    request(1'b0, 14'h0100, 8'h00, 1'b1, 8'h42, 8'd255);
    for (int i = 0; i < 300; i++)
      ce_cycle();
    check("t6_stall_sat", {24'd0, stall}, 32'd255);
    vRd = 1'b0;
    wait_ack("t6_ack_seen", 4);

    // Reset in the middle of an ACCESS write
    request(1'b1, 14'h0200, 8'h11, 1'b0, 8'h00, 8'd0);
    ce_cycle();
    check("t7_we_access", {31'd0, memWe}, 32'd1);
    a0 = ack_count;
    #2;
    reset = 1'b1;
    #1;
    check("t7_we_dropped", {31'd0, memWe},  32'd0);
    check("t7_stall_clr",  {24'd0, stall},  32'd0);
    check("t7_memA_clr",   {18'd0, memA},   32'd0);
    check("t7_cpuDo_clr",  {24'd0, cpuDo},  32'd0);
    cpuReq = 1'b0;
    ce_cycle();
    ce_cycle();
    reset = 1'b0;
    ce_cycle();
    ce_cycle();
    check("t7_no_ack", ack_count - a0, 32'd0);

    // First request after reset is taken on the first ce
    memDi = 8'h99;
    request(1'b0, 14'h1234, 8'h00, 1'b1, 8'h99, 8'd0);
    ce_cycle();
    check("t8_memA", {18'd0, memA}, 32'h1234);
    wait_ack("t8_ack_seen", 4);
    ce_cycle();

    check("sb_empty", sb_q.size(), 32'd0);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
